// File: rtl/i2c_slave_regfile_if.sv
// rtl/i2c_slave_regfile_if.sv - byte-engine handshake between i2c_slave and its register bank
interface i2c_slave_regfile_if;
   logic       i2c_ack;
   logic       i2c_w;
   logic       i2c_r;
   logic [7:0] i2c_rxdata;
   logic       i2c_stop;
   logic [7:0] i2c_txdata;

   modport master (
      output i2c_ack, i2c_w, i2c_r, i2c_rxdata, i2c_stop,
      input  i2c_txdata
   );

   modport slave (
      input  i2c_ack, i2c_w, i2c_r, i2c_rxdata, i2c_stop,
      output i2c_txdata
   );
endinterface

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - pointer-addressed register bank behind the i2c_slave byte engine
module i2c_slave_regfile #(
   parameter int unsigned             NUM_REGS = 16,
   parameter int unsigned             PTR_W    = 8,
   parameter logic [8*NUM_REGS-1:0]   RST_VAL  = '0,
   parameter logic [NUM_REGS-1:0]     RO_MASK  = '0,
   parameter bit                      AUTO_INC = 1'b1,
   parameter bit                      WRAP     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   i2c_slave_regfile_if.slave    i2c,
   input  logic                  hw_wr,
   input  logic [PTR_W-1:0]      hw_addr,
   input  logic [7:0]            hw_wdata,
   output logic [8*NUM_REGS-1:0] regs_flat,
   output logic                  wr_pulse,
   output logic [PTR_W-1:0]      wr_addr,
   output logic                  err_sticky
);

   typedef enum logic {IDLE, DATA} state_t;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             ack_prev_q;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       regs_d [NUM_REGS];
   logic             wr_pulse_q, wr_pulse_d;
   logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
   logic             err_q, err_d;

   logic             ack_rise;
   logic             ptr_hit;
   logic             ro_hit;
   logic [7:0]       tx_data;
   logic [PTR_W-1:0] ptr_next;

   // Pointer decode: a pointer outside the bank matches no register.
   always_comb begin
      ack_rise = i2c.i2c_ack & ~ack_prev_q;
      ptr_hit  = 1'b0;
      ro_hit   = 1'b0;
      tx_data  = 8'hFF;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (ptr_q == PTR_W'(k)) begin
            ptr_hit = 1'b1;
            ro_hit  = RO_MASK[k];
            tx_data = regs_q[k];
         end
      end

      if (!AUTO_INC || !ptr_hit) begin
         ptr_next = ptr_q;
      end else if (ptr_q == LAST_PTR) begin
         ptr_next = WRAP ? '0 : LAST_PTR;
      end else begin
         ptr_next = ptr_q + PTR_W'(1);
      end
   end

   assign i2c.i2c_txdata = tx_data;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      err_d      = err_q;
      regs_d     = regs_q;

      for (int k = 0; k < NUM_REGS; k++) begin
         if (hw_wr && hw_addr == PTR_W'(k)) begin
            regs_d[k] = hw_wdata;
         end
      end

      // The I2C commit is applied after the fabric write so it wins on a shared register.
      if (ack_rise) begin
         case (state_q)
            IDLE: begin
               if (i2c.i2c_w) begin
                  ptr_d   = PTR_W'(i2c.i2c_rxdata);
                  state_d = DATA;
               end else if (i2c.i2c_r) begin
                  ptr_d = ptr_next;
               end
            end
            DATA: begin
               if (i2c.i2c_w) begin
                  if (ptr_hit && !ro_hit) begin
                     for (int k = 0; k < NUM_REGS; k++) begin
                        if (ptr_q == PTR_W'(k)) begin
                           regs_d[k] = i2c.i2c_rxdata;
                        end
                     end
                     wr_pulse_d = 1'b1;
                     wr_addr_d  = ptr_q;
                  end else begin
                     err_d = 1'b1;
                  end
                  ptr_d = ptr_next;
               end else if (i2c.i2c_r) begin
                  ptr_d = ptr_next;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (i2c.i2c_stop) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         ack_prev_q <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= RST_VAL[8*k +: 8];
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ack_prev_q <= i2c.i2c_ack;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         err_q      <= err_d;
         regs_q     <= regs_d;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_flat[8*k +: 8] = regs_q[k];
      end
   end

   assign wr_pulse   = wr_pulse_q;
   assign wr_addr    = wr_addr_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - scoreboard bench for i2c_slave_regfile
// Two banks share one stimulus stream: A wraps with no RO regs, B saturates with reg1 read-only.
module tb_i2c_slave_regfile;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ack = 1'b0, w = 1'b0, r = 1'b0, stop = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        hw_wr = 1'b0;
   logic [7:0]  hw_addr = 8'h00, hw_wdata = 8'h00;

   logic [31:0] flat_a, flat_b;
   logic        wrp_a, wrp_b, err_a, err_b;
   logic [7:0]  wra_a, wra_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   i2c_slave_regfile_if if_a ();
   i2c_slave_regfile_if if_b ();

   assign if_a.i2c_ack = ack;   assign if_b.i2c_ack = ack;
   assign if_a.i2c_w = w;       assign if_b.i2c_w = w;
   assign if_a.i2c_r = r;       assign if_b.i2c_r = r;
   assign if_a.i2c_rxdata = rxd; assign if_b.i2c_rxdata = rxd;
   assign if_a.i2c_stop = stop; assign if_b.i2c_stop = stop;

   i2c_slave_regfile #(.NUM_REGS(4), .PTR_W(8), .RST_VAL(32'h0000_0605),
                       .RO_MASK(4'b0000), .AUTO_INC(1'b1), .WRAP(1'b1)) dut_a (
      .clk(clk), .reset_n(reset_n), .i2c(if_a), .hw_wr(hw_wr), .hw_addr(hw_addr),
      .hw_wdata(hw_wdata), .regs_flat(flat_a), .wr_pulse(wrp_a), .wr_addr(wra_a),
      .err_sticky(err_a));

   i2c_slave_regfile #(.NUM_REGS(4), .PTR_W(8), .RST_VAL(32'h0000_0605),
                       .RO_MASK(4'b0010), .AUTO_INC(1'b1), .WRAP(1'b0)) dut_b (
      .clk(clk), .reset_n(reset_n), .i2c(if_b), .hw_wr(hw_wr), .hw_addr(hw_addr),
      .hw_wdata(hw_wdata), .regs_flat(flat_b), .wr_pulse(wrp_b), .wr_addr(wra_b),
      .err_sticky(err_b));

   int         m_ptr [2];
   bit         m_dat [2];
   bit         m_err [2];
   logic [7:0] m_reg [2][4];
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dut_reg(input int x, input int k);
      logic [31:0] f;
      f = (x == 0) ? flat_a : flat_b;
      return f[8*k +: 8];
   endfunction

   function automatic bit is_ro(input int x, input int k);
      return (x == 1) && (k == 1);
   endfunction

   task automatic model_reset();
      for (int x = 0; x < 2; x++) begin
         m_ptr[x] = 0; m_dat[x] = 0; m_err[x] = 0;
         m_reg[x][0] = 8'h05; m_reg[x][1] = 8'h06; m_reg[x][2] = 8'h00; m_reg[x][3] = 8'h00;
      end
   endtask

   task automatic adv(input int x);
      if (m_ptr[x] < 4) begin
         if (m_ptr[x] == 3) m_ptr[x] = (x == 0) ? 0 : 3;
         else m_ptr[x] = m_ptr[x] + 1;
      end
   endtask

   function automatic logic [7:0] exp_tx(input int x);
      return (m_ptr[x] < 4) ? m_reg[x][m_ptr[x]] : 8'hFF;
   endfunction

   task automatic check_state(input string tag);
      for (int x = 0; x < 2; x++) begin
         for (int k = 0; k < 4; k++)
            chk($sformatf("%s_%s_reg%0d", tag, x ? "b" : "a", k), dut_reg(x, k), m_reg[x][k]);
         chk($sformatf("%s_%s_tx", tag, x ? "b" : "a"), x ? if_b.i2c_txdata : if_a.i2c_txdata, exp_tx(x));
         chk($sformatf("%s_%s_err", tag, x ? "b" : "a"), x ? err_b : err_a, m_err[x]);
      end
   endtask

   task automatic wbyte(input logic [7:0] d, input bit hw_en = 1'b0,
                        input logic [7:0] ha = 8'h00, input logic [7:0] hd = 8'h00);
      for (int x = 0; x < 2; x++) begin
         int ca;
         ca = -1;
         if (!m_dat[x]) begin
            m_ptr[x] = d;
            m_dat[x] = 1;
         end else begin
            if (m_ptr[x] < 4 && !is_ro(x, m_ptr[x])) begin
               m_reg[x][m_ptr[x]] = d;
               ca = m_ptr[x];
               if (x == 0) q_a.push_back({8'(m_ptr[x]), d});
               else        q_b.push_back({8'(m_ptr[x]), d});
            end else begin
               m_err[x] = 1;
            end
            adv(x);
         end
         if (hw_en && ha < 4 && int'(ha) != ca) m_reg[x][ha] = hd;
      end
      @(negedge clk);
      w = 1'b1; r = 1'b0; rxd = d; ack = 1'b1;
      hw_wr = hw_en; hw_addr = ha; hw_wdata = hd;
      @(negedge clk);
      hw_wr = 1'b0;
      @(negedge clk);
      ack = 1'b0; w = 1'b0;
      @(negedge clk);
   endtask

   task automatic rbyte(input string tag);
      chk({tag, "_a_tx"}, if_a.i2c_txdata, exp_tx(0));
      chk({tag, "_b_tx"}, if_b.i2c_txdata, exp_tx(1));
      adv(0); adv(1);
      @(negedge clk);
      r = 1'b1; w = 1'b0; ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ack = 1'b0; r = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_stop();
      m_dat[0] = 0; m_dat[1] = 0;
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_state(tag);
      chk({tag, "_wrp"}, {wrp_a, wrp_b}, 2'b00);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Scoreboard: every committed I2C write must match the oldest expected commit.
   always @(negedge clk) begin
      if (wrp_a) begin
         if (q_a.size() == 0) chk("a_wr_unexpected", {24'h0, wra_a}, 32'hFFFF_FFFF);
         else begin
            logic [15:0] e;
            e = q_a.pop_front();
            chk("a_wr_addr", wra_a, e[15:8]);
            chk("a_wr_data", dut_reg(0, int'(e[15:8])), e[7:0]);
         end
      end
      if (wrp_b) begin
         if (q_b.size() == 0) chk("b_wr_unexpected", {24'h0, wra_b}, 32'hFFFF_FFFF);
         else begin
            logic [15:0] e;
            e = q_b.pop_front();
            chk("b_wr_addr", wra_b, e[15:8]);
            chk("b_wr_data", dut_reg(1, int'(e[15:8])), e[7:0]);
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_state("rst");
      chk("rst_flat_a", flat_a[15:0], 16'h0605);
      chk("rst_wr_addr", {wra_a, wra_b}, 16'h0000);
      reset_n = 1'b1;
      @(negedge clk);

      wbyte(8'h02); wbyte(8'hA5); wbyte(8'h5A);
      do_stop();
      check_state("t2");

      do_reset("t3rst");
      wbyte(8'h01);
      do_stop();
      rbyte("t3r0"); rbyte("t3r1"); rbyte("t3r2");
      check_state("t3");

      do_reset("t4rst");
      wbyte(8'h03); wbyte(8'h11); wbyte(8'h22);
      check_state("t4");
      do_stop();

      wbyte(8'h01); wbyte(8'hFF);
      do_stop();
      check_state("t5ro");
      wbyte(8'h09);
      check_state("t5oor_ptr");
      wbyte(8'hAB);
      do_stop();
      check_state("t5oor");

      do_reset("t6rst");
      wbyte(8'h02);
      wbyte(8'h44, 1'b1, 8'h02, 8'h33);
      wbyte(8'h55, 1'b1, 8'h00, 8'h77);
      wbyte(8'h66, 1'b1, 8'h07, 8'h88);
      do_stop();
      check_state("t6");

      @(negedge clk);
      w = 1'b1; rxd = 8'h99; ack = 1'b1;
      #2 reset_n = 1'b0;
      #3 ack = 1'b0; w = 1'b0;
      model_reset();
      @(negedge clk);
      check_state("t6mid");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check_state("t6post");

      chk("a_wr_left", q_a.size(), 0);
      chk("b_wr_left", q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
